// File: rtl/puf_pkg.sv
// Shared types and default sizing for the PUF key-capture datapath.
package puf_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCount   = 2'd1,
    StCompare = 2'd2,
    StFull    = 2'd3
  } state_e;

  localparam int unsigned DefNPairs  = 8;
  localparam int unsigned DefKeyBits = 8;
  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefMargin  = 4;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefPairW = idx_width(DefNPairs);

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises a whole RO bank, detects rising edges, and counts edges of the
// selected lane with a saturating, clearable counter.
module ro_edge_counter import puf_pkg::*; #(
  parameter int unsigned NPairs = DefNPairs,
  parameter int unsigned CntW   = DefCntW,
  localparam int unsigned SelW  = idx_width(NPairs)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NPairs-1:0] ro_i,
  input  logic [SelW-1:0]   sel_i,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [CntW-1:0]   cnt_o
);

  logic [NPairs-1:0] sync1_q, sync2_q, prev_q;
  logic [NPairs-1:0] edge_vec;
  logic              sel_edge;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Every lane is synchronised continuously so switching lanes never sees stale history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign edge_vec = sync2_q & ~prev_q;
  assign sel_edge = edge_vec[sel_i];

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && sel_edge && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/puf_key_capture.sv
// PUF key capture: one RO-pair comparison per measurement window, one key bit per window.
// Optional STABILITY_MASK_EN adds unstable_mask_o flagging bits whose counts differ by < Margin.
module puf_key_capture import puf_pkg::*; #(
  parameter int unsigned NPairs  = DefNPairs,
  parameter int unsigned KeyBits = DefKeyBits,
  parameter int unsigned CntW    = DefCntW,
`ifdef STABILITY_MASK_EN
  parameter int unsigned Margin  = DefMargin,
`endif
  localparam int unsigned PairW  = idx_width(NPairs)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_count_i,
  input  logic               done_in_i,
  input  logic [NPairs-1:0]  ro_a_i,
  input  logic [NPairs-1:0]  ro_b_i,
  input  logic               key_clear_i,
  output logic [KeyBits-1:0] key_o,
  output logic               key_valid_o,
  output logic [PairW-1:0]   pair_sel_o,
  output logic               busy_o,
`ifdef STABILITY_MASK_EN
  output logic [KeyBits-1:0] unstable_mask_o,
`endif
  output logic               tie_flag_o
);

  localparam int unsigned IdxW = idx_width(KeyBits);

  state_e             state_q, state_d;
  logic               start_prev_q;
  logic [KeyBits-1:0] key_q, key_d;
  logic               key_valid_q, key_valid_d;
  logic [PairW-1:0]   pair_q, pair_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               tie_q, tie_d;
  logic [CntW-1:0]    cnt_a, cnt_b;
  logic               start_rise, cnt_clr, cnt_en;
`ifdef STABILITY_MASK_EN
  logic [KeyBits-1:0] mask_q, mask_d;
  logic [CntW:0]      cnt_diff;

  assign cnt_diff = (cnt_a >= cnt_b) ? ({1'b0, cnt_a} - {1'b0, cnt_b})
                                     : ({1'b0, cnt_b} - {1'b0, cnt_a});
`endif

  ro_edge_counter #(
    .NPairs (NPairs),
    .CntW   (CntW)
  ) u_cnt_a (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ro_i   (ro_a_i),
    .sel_i  (pair_q),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt_a)
  );

  ro_edge_counter #(
    .NPairs (NPairs),
    .CntW   (CntW)
  ) u_cnt_b (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ro_i   (ro_b_i),
    .sel_i  (pair_q),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt_b)
  );

  assign start_rise = start_count_i & ~start_prev_q;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    pair_d      = pair_q;
    idx_d       = idx_q;
    tie_d       = tie_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
`ifdef STABILITY_MASK_EN
    mask_d      = mask_q;
`endif
    if (key_clear_i) begin
      state_d     = StIdle;
      key_d       = '0;
      key_valid_d = 1'b0;
      pair_d      = '0;
      idx_d       = '0;
      tie_d       = 1'b0;
`ifdef STABILITY_MASK_EN
      mask_d      = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_rise) begin
            cnt_clr = 1'b1;
            state_d = StCount;
          end
        end
        StCount: begin
          cnt_en = 1'b1;
          if (!start_count_i || done_in_i) state_d = StCompare;
        end
        StCompare: begin
          key_d[idx_q] = (cnt_a > cnt_b);
          if (cnt_a == cnt_b) tie_d = 1'b1;
`ifdef STABILITY_MASK_EN
          mask_d[idx_q] = (cnt_diff < (CntW+1)'(Margin));
`endif
          pair_d = (pair_q == PairW'(NPairs - 1)) ? '0 : pair_q + PairW'(1);
          if (idx_q == IdxW'(KeyBits - 1)) begin
            key_valid_d = 1'b1;
            state_d     = StFull;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StIdle;
          end
        end
        StFull: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      // Treated as already high so a window open across reset release is not captured.
      start_prev_q <= 1'b1;
      key_q        <= '0;
      key_valid_q  <= 1'b0;
      pair_q       <= '0;
      idx_q        <= '0;
      tie_q        <= 1'b0;
`ifdef STABILITY_MASK_EN
      mask_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_count_i;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      pair_q       <= pair_d;
      idx_q        <= idx_d;
      tie_q        <= tie_d;
`ifdef STABILITY_MASK_EN
      mask_q       <= mask_d;
`endif
    end
  end

  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  assign pair_sel_o  = pair_q;
  assign busy_o      = (state_q == StCount) || (state_q == StCompare);
  assign tie_flag_o  = tie_q;
`ifdef STABILITY_MASK_EN
  assign unstable_mask_o = mask_q;
`endif

endmodule
